regfile_wb_arbiter: RTL

Shares the single register-file write port among N_REQ writeback requesters (ALU, LSU, MDU).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write-port outputs drive the register file directly.
- Integrated scoreboard tracks destination registers with writes still outstanding; decode uses it for RAW/WAW stall.

---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the register-file writeback arbiter
package regfile_wb_arbiter_pkg;

   localparam int RF_AW    = 5;
   localparam int RF_DW    = 32;
   localparam int REG_ZERO = 0;

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_MDU = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - one-hot wrap-around priority select with pointer
// ARB_FIXED_PRIO_EN selects lowest-index-wins priority and removes the pointer.
module rr_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [2:0]       grant_idx,
   output logic             any
);

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = 3'(i);
            any       = 1'b1;
         end
      end
   end
`else
   logic [2:0] ptr;

   always_comb begin
      int c;
      c         = 0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= N_REQ) c = c - N_REQ;
         if (!any && req[c]) begin
            any       = 1'b1;
            grant[c]  = 1'b1;
            grant_idx = 3'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         ptr <= '0;
      else if (any)
         ptr <= (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback port arbiter with registered RF write and busy scoreboard
// ARB_FIXED_PRIO_EN (in rr_arbiter) switches round-robin to fixed priority.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int AW    = RF_AW,
   parameter int DW    = RF_DW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_addr,
   output logic                rf_we,
   output logic [AW-1:0]       rf_waddr,
   output logic [DW-1:0]       rf_wdata,
   output logic [2**AW-1:0]    busy,
   output logic [2:0]          grant_idx
);

   logic [N_REQ-1:0] grant;
   logic [2:0]       sel_idx;
   logic             any_grant;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_data;
   logic [2**AW-1:0] busy_next;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .grant     (grant),
      .grant_idx (sel_idx),
      .any       (any_grant)
   );

   assign req_ready = grant;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Set after clear: a same-cycle issue means a newer instruction owns the register.
   always_comb begin
      busy_next = busy;
      if (any_grant)
         busy_next[sel_addr] = 1'b0;
      if (issue_valid)
         busy_next[issue_addr] = 1'b1;
      busy_next[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         busy      <= '0;
         grant_idx <= '0;
      end else begin
         rf_we <= any_grant && (sel_addr != AW'(REG_ZERO));
         if (any_grant) begin
            rf_waddr  <= sel_addr;
            rf_wdata  <= sel_data;
            grant_idx <= sel_idx;
         end
         busy <= busy_next;
      end
   end

endmodule
